// File: rtl/button_pulse_gen.sv
// Push-button debouncer: turns each qualified press into a one-cycle enable strobe,
// with optional auto-repeat while held. Exports the debounced level and a repeat flag.
module button_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 8,
   parameter int unsigned REPEAT_CYCLES   = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_in,
   output logic enable,
   output logic btn_level,
   output logic repeat_active
);

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StHeld,
      StRepeat,
      StRel
   } state_e;

   localparam logic [15:0] DebLast  = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] RepLast  = (REPEAT_CYCLES == 0) ? 16'd0 : 16'(REPEAT_CYCLES - 1);
   localparam bit          RepeatEn = (REPEAT_CYCLES != 0);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        s1_q, btn_s_q;
   logic        strobe;
   logic [15:0] cnt_inc;

   // Two-flop synchronizer; the raw input is never used past this point.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         btn_s_q <= 1'b0;
      end else begin
         s1_q    <= btn_in;
         btn_s_q <= s1_q;
      end
   end

   assign cnt_inc = cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      strobe  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (btn_s_q) begin
               state_d = StArm;
               cnt_d   = '0;
            end
         end
         StArm: begin
            if (!btn_s_q) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               state_d = StHeld;
               cnt_d   = '0;
               strobe  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StHeld: begin
            if (!btn_s_q) begin
               state_d = StRel;
               cnt_d   = '0;
            end else if (RepeatEn && (cnt_q == HoldLast)) begin
               state_d = StRepeat;
               cnt_d   = '0;
               strobe  = 1'b1;
            end else if (cnt_q != '1) begin
               // Saturates only when auto-repeat is disabled.
               cnt_d = cnt_inc;
            end
         end
         StRepeat: begin
            if (!btn_s_q) begin
               state_d = StRel;
               cnt_d   = '0;
            end else if (cnt_q == RepLast) begin
               cnt_d  = '0;
               strobe = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StRel: begin
            if (btn_s_q) begin
               state_d = StHeld;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they align with the transition edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         enable        <= 1'b0;
         btn_level     <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         enable        <= strobe;
         btn_level     <= (state_d == StHeld) || (state_d == StRepeat) || (state_d == StRel);
         repeat_active <= (state_d == StRepeat);
      end
   end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: two instances (repeat period 3 and repeat disabled) driven by
// one button, checked against a run-length reference model plus vector tables and sequences.
module tb_button_pulse_gen;

   localparam int unsigned D = 4;
   localparam int unsigned H = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic btn_in = 1'b0;
   logic en_a, lvl_a, ra_a;
   logic en_b, lvl_b, ra_b;

   button_pulse_gen #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .REPEAT_CYCLES  (3)
   ) dut_a (
      .clock        (clock),
      .reset        (reset),
      .btn_in       (btn_in),
      .enable       (en_a),
      .btn_level    (lvl_a),
      .repeat_active(ra_a)
   );

   button_pulse_gen #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .REPEAT_CYCLES  (0)
   ) dut_b (
      .clock        (clock),
      .reset        (reset),
      .btn_in       (btn_in),
      .enable       (en_b),
      .btn_level    (lvl_b),
      .repeat_active(ra_b)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_no  = 0;
   int strobes_a[$];
   int strobes_b[$];
   logic prev_en_a = 1'b0;

   // Reference model: debounced level from run lengths of the synchronized samples,
   // repeat strobes from the time the button has been continuously held.
   bit          sync1, sync2;
   bit          m_lvl[2];
   int unsigned m_ones[2], m_zeros[2], m_age[2];
   bit          x_en[2], x_lvl[2], x_ra[2];

   function automatic int unsigned rep_of(input int k);
      return (k == 0) ? 3 : 0;
   endfunction

   function automatic void model_reset();
      sync1 = 1'b0;
      sync2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_lvl[k] = 1'b0; m_ones[k] = 0; m_zeros[k] = 0; m_age[k] = 0;
         x_en[k] = 1'b0; x_lvl[k] = 1'b0; x_ra[k] = 1'b0;
      end
   endfunction

   function automatic void model_edge(input int k, input bit s);
      int unsigned rep = rep_of(k);
      x_en[k] = 1'b0;
      if (!m_lvl[k]) begin
         m_ones[k] = s ? m_ones[k] + 1 : 0;
         if (m_ones[k] == D + 1) begin
            m_lvl[k] = 1'b1; x_en[k] = 1'b1; m_age[k] = 0; m_zeros[k] = 0;
         end
      end else if (!s) begin
         m_zeros[k]++;
         if (m_zeros[k] == D + 1) begin
            m_lvl[k] = 1'b0; m_ones[k] = 0; m_zeros[k] = 0;
         end
      end else if (m_zeros[k] != 0) begin
         m_zeros[k] = 0;
         m_age[k]   = 0;
      end else begin
         m_age[k]++;
         if (rep != 0 && m_age[k] >= H && ((m_age[k] - H) % rep) == 0) x_en[k] = 1'b1;
      end
      x_lvl[k] = m_lvl[k];
      x_ra[k]  = m_lvl[k] && (m_zeros[k] == 0) && (rep != 0) && (m_age[k] >= H);
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: edge %0d got %b expected %b", name, edge_no, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive on the falling edge, advance the model at the rising edge, sample 1ns later.
   task automatic step(input logic b);
      bit s;
      @(negedge clock);
      btn_in = b;
      @(posedge clock);
      s = sync2; sync2 = sync1; sync1 = b;
      model_edge(0, s);
      model_edge(1, s);
      edge_no++;
      #1;
      check("model_enable_r3", en_a, x_en[0]);
      check("model_level_r3", lvl_a, x_lvl[0]);
      check("model_repeat_r3", ra_a, x_ra[0]);
      check("model_enable_r0", en_b, x_en[1]);
      check("model_level_r0", lvl_b, x_lvl[1]);
      check("model_repeat_r0", ra_b, x_ra[1]);
      check("no_back_to_back_enable", prev_en_a && en_a, 1'b0);
      prev_en_a = en_a;
      if (en_a) strobes_a.push_back(edge_no);
      if (en_b) strobes_b.push_back(edge_no);
   endtask

   task automatic go_idle();
      repeat (12) step(1'b0);
      edge_no = 0;
      strobes_a.delete();
      strobes_b.delete();
   endtask

   task automatic check_strobes(input string name, input int exp[$], input int got[$]);
      check_int({name, "_count"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check_int({name, "_edge"}, (i < got.size()) ? got[i] : -1, exp[i]);
   endtask

   typedef struct {
      logic b;
      logic en;
      logic lvl;
      logic ra;
   } vec_t;

   vec_t tbl[22];

   initial begin
      int ra_rise, lvl_fall, low_lvl;
      int exp_q[$];

      // Clean press: held 12 edges, strobe and level rise after edge 7, level falls after 19.
      for (int i = 0; i < 22; i++) begin
         tbl[i].b   = (i + 1 <= 12);
         tbl[i].en  = (i + 1 == 7);
         tbl[i].lvl = (i + 1 >= 7) && (i + 1 <= 18);
         tbl[i].ra  = 1'b0;
      end

      reset = 1'b1;
      model_reset();
      #1;
      check("reset_enable", en_a, 1'b0);
      check("reset_level", lvl_a, 1'b0);
      check("reset_repeat", ra_a, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;

      go_idle();
      for (int i = 0; i < 22; i++) begin
         step(tbl[i].b);
         check("tbl_enable", en_a, tbl[i].en);
         check("tbl_level", lvl_a, tbl[i].lvl);
         check("tbl_repeat", ra_a, tbl[i].ra);
      end

      // Bounce on press: 3 high, 1 low, then high; single strobe after edge 11.
      go_idle();
      repeat (3) step(1'b1);
      step(1'b0);
      repeat (12) step(1'b1);
      exp_q = '{11};
      check_strobes("bounce_press", exp_q, strobes_a);

      // Auto-repeat over a 30-edge hold, then release.
      go_idle();
      ra_rise  = -1;
      lvl_fall = -1;
      repeat (30) begin
         step(1'b1);
         if (ra_a && ra_rise < 0) ra_rise = edge_no;
      end
      repeat (10) begin
         step(1'b0);
         if (!lvl_a && lvl_fall < 0) lvl_fall = edge_no;
      end
      exp_q = '{7, 15, 18, 21, 24, 27, 30};
      check_strobes("auto_repeat", exp_q, strobes_a);
      check_int("repeat_active_rise", ra_rise, 15);
      check_int("release_level_fall", lvl_fall, 37);
      exp_q = '{7};
      check_strobes("no_repeat_30", exp_q, strobes_b);

      // Release bounce in HELD: level stays high, hold timer restarts at edge 15.
      go_idle();
      low_lvl = 0;
      repeat (10) step(1'b1);
      repeat (2) step(1'b0);
      repeat (12) begin
         step(1'b1);
         if (!lvl_a) low_lvl++;
      end
      check_int("release_bounce_level_low", low_lvl, 0);
      exp_q = '{7, 23};
      check_strobes("release_bounce", exp_q, strobes_a);

      // REPEAT_CYCLES=0 instance: 40-edge hold yields one strobe and never repeats.
      go_idle();
      ra_rise = 0;
      repeat (40) begin
         step(1'b1);
         if (ra_b) ra_rise++;
      end
      exp_q = '{7};
      check_strobes("repeat_disabled", exp_q, strobes_b);
      check_int("repeat_disabled_ra", ra_rise, 0);

      // Reset mid-REPEAT with the button still held.
      go_idle();
      repeat (20) step(1'b1);
      check("pre_reset_repeat", ra_a, 1'b1);
      #3 reset = 1'b1;
      #1;
      check("async_reset_enable", en_a, 1'b0);
      check("async_reset_level", lvl_a, 1'b0);
      check("async_reset_repeat", ra_a, 1'b0);
      check("async_reset_level_r0", lvl_b, 1'b0);
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      edge_no = 0;
      strobes_a.delete();
      strobes_b.delete();
      repeat (10) step(1'b1);
      exp_q = '{7};
      check_strobes("post_reset_r3", exp_q, strobes_a);
      check_strobes("post_reset_r0", exp_q, strobes_b);

      // Random bursts of varying length against the model.
      go_idle();
      for (int n = 0; n < 60; n++) begin
         logic b;
         int   len;
         b   = 1'($urandom_range(0, 1));
         len = (n % 4 == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 7));
         repeat (len) step(b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
